// File: rtl/cordiv_sched.sv
// cordiv_sched: sequencer for one regenerating correlated stochastic (CORDIV) divider.
// Define CORDIV_SCHED_PROGLEN_EN to add a len_log2 input that selects a 2^len_log2 run.
module cordiv_sched #(
  parameter int         WIDTH    = 8,
  parameter int         WARMUP   = 16,
  parameter logic [7:0] SEED     = 8'hA5,
  parameter logic [7:0] SEL_SEED = 8'h3C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_dividend,
  input  logic [WIDTH-1:0] op_divisor,
`ifdef CORDIV_SCHED_PROGLEN_EN
  input  logic [3:0]       len_log2,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] rand_num,
  output logic             sel,
  output logic             div_dividend,
  output logic             div_divisor,
  input  logic             div_quotient,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int             PW      = (WIDTH + 1 > 8) ? WIDTH + 1 : 8;
  localparam logic [WIDTH:0] RES_MAX = (WIDTH+1)'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    phase;
  logic [WIDTH:0]   ones;
  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic [7:0]       lfsr, sel_lfsr;
  logic             active, warm_last, run_last;
  logic [WIDTH:0]   sum, scaled;
  logic [WIDTH-1:0] res_next;

  // Galois form of x^8+x^6+x^5+x^4+1 (right shift, tap mask 0xB8); never reaches 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  assign active       = (state == S_WARM) || (state == S_RUN);
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign rand_num     = WIDTH'(lfsr);
  assign sel          = sel_lfsr[0];
  // One shared rand_num for both comparators keeps the streams correlated.
  assign div_dividend = active && (dividend_q > rand_num);
  assign div_divisor  = active && (divisor_q > rand_num);

  assign warm_last = (phase == PW'(WARMUP - 1));
  assign sum       = ones + (WIDTH+1)'(div_quotient);

`ifdef CORDIV_SCHED_PROGLEN_EN
  logic [3:0] len_q, len_clamp;
  always_comb begin
    len_clamp = len_log2;
    if (len_log2 < 4'd4)               len_clamp = 4'd4;
    else if (32'(len_log2) > WIDTH)    len_clamp = 4'(WIDTH);
  end
  assign run_last = (phase == ((PW'(1) << len_q) - PW'(1)));
  // Short runs are rescaled to full-width so the result keeps its meaning.
  assign scaled   = sum << (4'(WIDTH) - len_q);
`else
  assign run_last = (phase == PW'((1 << WIDTH) - 1));
  assign scaled   = sum;
`endif

  assign res_next = (scaled > RES_MAX) ? RES_MAX[WIDTH-1:0] : scaled[WIDTH-1:0];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = (op_divisor == '0) ? S_DONE : S_WARM;
      S_WARM:  if (warm_last) state_n = S_RUN;
      S_RUN:   if (run_last) state_n = S_DONE;
      S_DONE:  if (result_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= '0;
      ones        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      lfsr        <= SEED;
      sel_lfsr    <= SEL_SEED;
      result      <= '0;
      div_by_zero <= 1'b0;
`ifdef CORDIV_SCHED_PROGLEN_EN
      len_q       <= 4'(WIDTH);
`endif
    end else begin
      if (active) begin
        lfsr     <= lfsr_step(lfsr);
        sel_lfsr <= lfsr_step(sel_lfsr);
      end
      case (state)
        S_IDLE: if (start) begin
          dividend_q <= op_dividend;
          divisor_q  <= op_divisor;
          lfsr       <= SEED;
          sel_lfsr   <= SEL_SEED;
          phase      <= '0;
          ones       <= '0;
`ifdef CORDIV_SCHED_PROGLEN_EN
          len_q      <= len_clamp;
`endif
          if (op_divisor == '0) begin
            result      <= '1;
            div_by_zero <= 1'b1;
          end
        end
        S_WARM: phase <= warm_last ? '0 : phase + PW'(1);
        S_RUN: begin
          ones  <= sum;
          phase <= phase + PW'(1);
          if (run_last) begin
            result      <= res_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordiv_sched.sv
// Directed bench for cordiv_sched with a small two-entry-history CORDIV divider model
// and a scoreboard of expected results computed from a reference stream model.
module tb_cordiv_sched;
  localparam int W  = 8;
  localparam int WU = 16;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, result_ready = 1'b0;
  logic [7:0] op_dividend = '0, op_divisor = '0;
`ifdef CORDIV_SCHED_PROGLEN_EN
  logic [3:0] len_log2 = 4'd8;
`endif
  logic       busy, sel, div_dividend, div_divisor, div_quotient, div_by_zero, result_valid;
  logic [7:0] rand_num, result;
  logic       dm_clr = 1'b0;
  logic [1:0] hist;
  int         n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct { logic [7:0] res; logic dbz; int lat; } exp_t;
  exp_t sb[$];

  cordiv_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .op_dividend(op_dividend), .op_divisor(op_divisor),
`ifdef CORDIV_SCHED_PROGLEN_EN
    .len_log2(len_log2),
`endif
    .busy(busy), .rand_num(rand_num), .sel(sel),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .result(result), .div_by_zero(div_by_zero),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider: pass the dividend bit when the divisor bit is 1, else regenerate from history.
  assign div_quotient = div_divisor ? div_dividend : hist[sel];
  always @(posedge clk or posedge rst)
    if (rst)         hist <= '0;
    else if (dm_clr) hist <= '0;
    else             hist <= {hist[0], div_quotient};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  // Reference: replay streams and divider from seeds, count quotient ones after warm-up.
  function automatic int model(input int a, input int b, input int lg);
    logic [7:0] r = 8'hA5, sl = 8'h3C;
    logic [1:0] h = 2'b00;
    logic       q;
    int         ones = 0, sc;
    for (int k = 0; k < WU + (1 << lg); k++) begin
      q = (b > int'(r)) ? (a > int'(r)) : h[sl[0]];
      if (k >= WU) ones += int'(q);
      h  = {h[0], q};
      r  = lstep(r);
      sl = lstep(sl);
    end
    sc = ones << (W - lg);
    return (sc > 255) ? 255 : sc;
  endfunction

  task automatic do_start(input int a, input int b, input int lg_in, output int acc);
    exp_t e;
    int   lg;
`ifdef CORDIV_SCHED_PROGLEN_EN
    lg = (lg_in < 4) ? 4 : ((lg_in > W) ? W : lg_in);
    len_log2 = 4'(lg_in);
`else
    lg = W;
`endif
    op_dividend = 8'(a); op_divisor = 8'(b); start = 1'b1; dm_clr = 1'b1;
    tick;
    start = 1'b0; dm_clr = 1'b0; acc = cyc;
    if (b == 0) begin e.res = 8'hFF; e.dbz = 1'b1; e.lat = 0; end
    else        begin e.res = 8'(model(a, b, lg)); e.dbz = 1'b0; e.lat = WU + (1 << lg); end
    sb.push_back(e);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_result(input int acc);
    exp_t e;
    int   n = 0;
    while (!result_valid && n < 400) begin tick; n++; end
    chk("result_valid", result_valid, 1);
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL scoreboard: got result with empty queue expected pending entry");
    end else begin
      e = sb.pop_front();
      chk("latency", 32'(cyc - acc), 32'(e.lat));
      chk("result", result, e.res);
      chk("div_by_zero", div_by_zero, e.dbz);
    end
  endtask

  task automatic release_result;
    result_ready = 1'b1; tick; result_ready = 1'b0;
    chk("valid_drop", result_valid, 0);
    chk("idle_after_ready", busy, 0);
  endtask

  task automatic check_rand_seq;
    logic [7:0] rv = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      chk("rand_seq", rand_num, rv);
      rv = lstep(rv);
      tick;
    end
  endtask

  initial begin
    int acc;
    rst = 1'b1; tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_rand", rand_num, 8'hA5);
    chk("rst_sel", sel, 0);
    chk("rst_streams", {div_dividend, div_divisor}, 0);
    chk("rst_result", result, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_valid", result_valid, 0);
    rst = 1'b0; tick;

    // Nominal divide 64/128.
    do_start(64, 128, 8, acc);
    check_rand_seq;
    wait_result(acc);
    release_result;

    // Zero divisor: immediate result, streams stay quiet.
    do_start(50, 0, 8, acc);
    wait_result(acc);
    for (int i = 0; i < 3; i++) begin
      chk("zero_div_streams", {div_dividend, div_divisor}, 0);
      tick;
    end
    release_result;

    // Saturation, then backpressure with ignored starts.
    do_start(200, 100, 8, acc);
    wait_result(acc);
    chk("sat_255", result, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      op_dividend = 8'd10; op_divisor = 8'd0; start = (i % 5 == 0);
      tick;
      start = 1'b0;
      chk("bp_valid", result_valid, 1);
      chk("bp_result", result, 8'hFF);
      chk("bp_dbz", div_by_zero, 0);
    end
    start = 1'b1; result_ready = 1'b1; tick; start = 1'b0; result_ready = 1'b0;
    chk("ready_wins_valid", result_valid, 0);
    chk("ready_wins_busy", busy, 0);
    tick;
    chk("start_dropped", busy, 0);

    // Reset in the middle of RUN.
    do_start(64, 128, 8, acc);
    while (cyc - acc < WU + 100) tick;
    chk("in_run_busy", busy, 1);
    rst = 1'b1; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rand", rand_num, 8'hA5);
    chk("midrst_sel", sel, 0);
    chk("midrst_streams", {div_dividend, div_divisor}, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_dbz", div_by_zero, 0);
    sb.delete();
    tick; rst = 1'b0; tick;

    // Re-run must reproduce the nominal result and rand_num sequence.
    do_start(64, 128, 8, acc);
    check_rand_seq;
    wait_result(acc);
    release_result;

`ifdef CORDIV_SCHED_PROGLEN_EN
    do_start(64, 128, 4, acc);
    wait_result(acc);
    chk("len4_mult16", result[3:0], 0);
    release_result;
    do_start(64, 128, 2, acc);
    wait_result(acc);
    chk("len2_mult16", result[3:0], 0);
    release_result;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
